// File: rtl/scpad_pkg.sv
// Shared scratchpad geometry constants.
package scpad_pkg;
  localparam int unsigned NUM_COLS      = 32;
  localparam int unsigned ROW_IDX_WIDTH = 8;
endpackage

// File: rtl/scpad_tile_seq.sv
// Tile command sequencer: expands one tile command into per-row or per-column swizzle beats.
// Optional stall counter enabled by defining SCPAD_TILE_SEQ_PERF_EN.
module scpad_tile_seq #(
  parameter int unsigned NUM_COLS      = scpad_pkg::NUM_COLS,
  parameter int unsigned ROW_IDX_WIDTH = scpad_pkg::ROW_IDX_WIDTH,
  parameter int unsigned COL_IDX_WIDTH = $clog2(NUM_COLS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ROW_IDX_WIDTH-1:0] cmd_spad_addr,
  input  logic [COL_IDX_WIDTH-1:0] cmd_num_rows,
  input  logic [COL_IDX_WIDTH-1:0] cmd_num_cols,
  input  logic                     cmd_row_or_col,
  input  logic                     abort,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic [ROW_IDX_WIDTH-1:0] req_spad_addr,
  output logic                     req_row_or_col,
  output logic [COL_IDX_WIDTH-1:0] req_num_rows,
  output logic [COL_IDX_WIDTH-1:0] req_num_cols,
  output logic [ROW_IDX_WIDTH-1:0] req_row_id,
  output logic [COL_IDX_WIDTH-1:0] req_col_id,
  output logic                     req_last,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              perf_stall_cycles
);

  typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

  state_e                   state_q, state_d;
  logic [COL_IDX_WIDTH-1:0] beat_q, beat_d;
  logic [ROW_IDX_WIDTH-1:0] addr_q, addr_d;
  logic [COL_IDX_WIDTH-1:0] num_rows_q, num_rows_d;
  logic [COL_IDX_WIDTH-1:0] num_cols_q, num_cols_d;
  logic                     row_or_col_q, row_or_col_d;
  logic [COL_IDX_WIDTH-1:0] limit;
  logic                     at_limit;

  assign limit    = row_or_col_q ? num_rows_q : num_cols_q;
  assign at_limit = (beat_q == limit);

  // Abort blocks acceptance so a command offered alongside it is not lost silently.
  assign cmd_ready      = (state_q == StIdle) && !rst && !abort;
  assign req_valid      = (state_q == StIssue);
  assign req_last       = (state_q == StIssue) && at_limit;
  assign busy           = (state_q != StIdle);
  assign done           = (state_q == StDone);
  assign req_spad_addr  = addr_q;
  assign req_row_or_col = row_or_col_q;
  assign req_num_rows   = num_rows_q;
  assign req_num_cols   = num_cols_q;
  assign req_row_id     = row_or_col_q ? ROW_IDX_WIDTH'(beat_q) : '0;
  assign req_col_id     = row_or_col_q ? '0 : beat_q;

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    addr_d       = addr_q;
    num_rows_d   = num_rows_q;
    num_cols_d   = num_cols_q;
    row_or_col_d = row_or_col_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          addr_d       = cmd_spad_addr;
          num_rows_d   = cmd_num_rows;
          num_cols_d   = cmd_num_cols;
          row_or_col_d = cmd_row_or_col;
          beat_d       = '0;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        if (req_ready) begin
          if (at_limit) state_d = StDone;
          else          beat_d  = beat_q + COL_IDX_WIDTH'(1);
        end
        // A beat handshaken alongside abort still went out; only the sequence stops.
        if (abort) state_d = StIdle;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      beat_q       <= '0;
      addr_q       <= '0;
      num_rows_q   <= '0;
      num_cols_q   <= '0;
      row_or_col_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      addr_q       <= addr_d;
      num_rows_q   <= num_rows_d;
      num_cols_q   <= num_cols_d;
      row_or_col_q <= row_or_col_d;
    end
  end

`ifdef SCPAD_TILE_SEQ_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (req_valid && !req_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_stall_cycles = stall_q;
`else
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_scpad_tile_seq.sv
// Directed self-checking bench for scpad_tile_seq using immediate assertions.
module tb_scpad_tile_seq;

  localparam int unsigned RW = 8;
  localparam int unsigned CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [RW-1:0] cmd_spad_addr;
  logic [CW-1:0] cmd_num_rows;
  logic [CW-1:0] cmd_num_cols;
  logic          cmd_row_or_col;
  logic          abort;
  logic          req_valid;
  logic          req_ready;
  logic [RW-1:0] req_spad_addr;
  logic          req_row_or_col;
  logic [CW-1:0] req_num_rows;
  logic [CW-1:0] req_num_cols;
  logic [RW-1:0] req_row_id;
  logic [CW-1:0] req_col_id;
  logic          req_last;
  logic          busy;
  logic          done;
  logic [31:0]   perf_stall_cycles;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_stall;

  always #5 clk = ~clk;

  scpad_tile_seq dut (
    .clk               (clk),
    .rst               (rst),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_spad_addr     (cmd_spad_addr),
    .cmd_num_rows      (cmd_num_rows),
    .cmd_num_cols      (cmd_num_cols),
    .cmd_row_or_col    (cmd_row_or_col),
    .abort             (abort),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_spad_addr     (req_spad_addr),
    .req_row_or_col    (req_row_or_col),
    .req_num_rows      (req_num_rows),
    .req_num_cols      (req_num_cols),
    .req_row_id        (req_row_id),
    .req_col_id        (req_col_id),
    .req_last          (req_last),
    .busy              (busy),
    .done              (done),
    .perf_stall_cycles (perf_stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then leave 1ns before new inputs are driven.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after inputs change, well before the next edge.
  task automatic settle();
    #2;
  endtask

  task automatic set_cmd(input logic v, input logic [RW-1:0] a, input logic [CW-1:0] r,
                         input logic [CW-1:0] c, input logic roc);
    cmd_valid      = v;
    cmd_spad_addr  = a;
    cmd_num_rows   = r;
    cmd_num_cols   = c;
    cmd_row_or_col = roc;
  endtask

  initial begin
    rst = 1'b1; abort = 1'b0; req_ready = 1'b0;
    set_cmd(1'b0, '0, '0, '0, 1'b0);
    exp_stall = 0;

    // Reset state
    cyc(); settle();
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_last", {31'd0, req_last}, 32'd0);
    chk("rst_perf", perf_stall_cycles, 32'd0);
    cyc(); rst = 1'b0; settle();
    chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Row-major, 4 beats back to back
    set_cmd(1'b1, 8'h10, 5'd3, 5'd31, 1'b1); req_ready = 1'b1; settle();
    chk("rm_accept_ready", {31'd0, cmd_ready}, 32'd1);
    cyc(); cmd_valid = 1'b0; settle();
    chk("rm_addr", {24'd0, req_spad_addr}, 32'h10);
    chk("rm_ncols", {27'd0, req_num_cols}, 32'd31);
    chk("rm_nrows", {27'd0, req_num_rows}, 32'd3);
    chk("rm_roc", {31'd0, req_row_or_col}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("rm_valid", {31'd0, req_valid}, 32'd1);
      chk("rm_row_id", {24'd0, req_row_id}, i);
      chk("rm_col_id", {27'd0, req_col_id}, 32'd0);
      chk("rm_last", {31'd0, req_last}, (i == 3) ? 32'd1 : 32'd0);
      chk("rm_busy", {31'd0, busy}, 32'd1);
      cyc(); settle();
    end
    chk("rm_done", {31'd0, done}, 32'd1);
    chk("rm_done_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rm_done_valid", {31'd0, req_valid}, 32'd0);
    chk("rm_done_busy", {31'd0, busy}, 32'd1);
    cyc(); settle();
    chk("rm_idle_done", {31'd0, done}, 32'd0);
    chk("rm_idle_busy", {31'd0, busy}, 32'd0);

    // Column-major with backpressure toggling 0/1
    set_cmd(1'b1, 8'h22, 5'd2, 5'd7, 1'b0); settle();
    cyc(); cmd_valid = 1'b0;
    for (int b = 0; b < 8; b++) begin
      for (int ph = 0; ph < 2; ph++) begin
        req_ready = (ph == 1); settle();
        chk("cm_valid", {31'd0, req_valid}, 32'd1);
        chk("cm_col_id", {27'd0, req_col_id}, b);
        chk("cm_row_id", {24'd0, req_row_id}, 32'd0);
        chk("cm_last", {31'd0, req_last}, (b == 7) ? 32'd1 : 32'd0);
        chk("cm_addr", {24'd0, req_spad_addr}, 32'h22);
        if (ph == 0) exp_stall++;
        cyc();
      end
    end
    req_ready = 1'b1; settle();
    chk("cm_done", {31'd0, done}, 32'd1);
`ifdef SCPAD_TILE_SEQ_PERF_EN
    chk("cm_perf", perf_stall_cycles, exp_stall);
`else
    chk("cm_perf_off", perf_stall_cycles, 32'd0);
`endif
    cyc(); settle();
    chk("cm_idle_done", {31'd0, done}, 32'd0);

    // Single beat
    set_cmd(1'b1, 8'h05, 5'd0, 5'd5, 1'b1); settle();
    cyc(); cmd_valid = 1'b0; settle();
    chk("sb_valid", {31'd0, req_valid}, 32'd1);
    chk("sb_last", {31'd0, req_last}, 32'd1);
    chk("sb_row_id", {24'd0, req_row_id}, 32'd0);
    cyc(); settle();
    chk("sb_done", {31'd0, done}, 32'd1);
    chk("sb_valid_off", {31'd0, req_valid}, 32'd0);
    cyc(); settle();

    // Abort after the second accepted beat of an 8-beat command
    set_cmd(1'b1, 8'h40, 5'd7, 5'd1, 1'b1); settle();
    cyc(); cmd_valid = 1'b0; settle();
    chk("ab_row0", {24'd0, req_row_id}, 32'd0);
    cyc(); settle();
    chk("ab_row1", {24'd0, req_row_id}, 32'd1);
    cyc(); abort = 1'b1; cmd_valid = 1'b1; settle();
    chk("ab_row2", {24'd0, req_row_id}, 32'd2);
    chk("ab_ready_issue", {31'd0, cmd_ready}, 32'd0);
    cyc(); abort = 1'b0; cmd_valid = 1'b0; settle();
    chk("ab_valid", {31'd0, req_valid}, 32'd0);
    chk("ab_done", {31'd0, done}, 32'd0);
    chk("ab_busy", {31'd0, busy}, 32'd0);
    chk("ab_ready", {31'd0, cmd_ready}, 32'd1);
    // Abort in IDLE blocks acceptance
    set_cmd(1'b1, 8'h41, 5'd0, 5'd2, 1'b0); abort = 1'b1; settle();
    chk("ab_idle_ready", {31'd0, cmd_ready}, 32'd0);
    cyc(); abort = 1'b0; settle();
    chk("ab_idle_busy", {31'd0, busy}, 32'd0);
    cyc(); cmd_valid = 1'b0; settle();
    for (int i = 0; i < 3; i++) begin
      chk("ab_next_col", {27'd0, req_col_id}, i);
      chk("ab_next_last", {31'd0, req_last}, (i == 2) ? 32'd1 : 32'd0);
      cyc(); settle();
    end
    abort = 1'b1; settle();
    chk("ab_in_done", {31'd0, done}, 32'd1);
    cyc(); abort = 1'b0; settle();
    chk("ab_after_done", {31'd0, busy}, 32'd0);

    // Reset mid-ISSUE at beat 5, with abort and a command pending
    set_cmd(1'b1, 8'h77, 5'd7, 5'd3, 1'b1); settle();
    cyc(); cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    settle();
    chk("rs_row5", {24'd0, req_row_id}, 32'd5);
    rst = 1'b1; abort = 1'b1; set_cmd(1'b1, 8'h12, 5'd0, 5'd0, 1'b1); settle();
    chk("rs_ready", {31'd0, cmd_ready}, 32'd0);
    cyc(); rst = 1'b0; abort = 1'b0; settle();
    chk("rs_valid", {31'd0, req_valid}, 32'd0);
    chk("rs_done", {31'd0, done}, 32'd0);
    chk("rs_busy", {31'd0, busy}, 32'd0);
    chk("rs_addr", {24'd0, req_spad_addr}, 32'd0);
    chk("rs_nrows", {27'd0, req_num_rows}, 32'd0);
    chk("rs_perf", perf_stall_cycles, 32'd0);
    // cmd_valid held: accepted in IDLE, refused in ISSUE and DONE, accepted again after
    chk("rs_accept1", {31'd0, cmd_ready}, 32'd1);
    cyc(); settle();
    chk("rs_issue_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rs_issue_addr", {24'd0, req_spad_addr}, 32'h12);
    cyc(); settle();
    chk("rs_done_pulse", {31'd0, done}, 32'd1);
    chk("rs_done_ready", {31'd0, cmd_ready}, 32'd0);
    cyc(); settle();
    chk("rs_accept2", {31'd0, cmd_ready}, 32'd1);
    cyc(); cmd_valid = 1'b0; settle();
    chk("rs_reissue", {31'd0, req_valid}, 32'd1);
    cyc(); cyc(); settle();
    chk("rs_final_idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
